// File: rtl/mp_adder_seq_if.sv
// Operand/result handshake bundle for the multi-precision sequential adder.
// W must equal N*K of the attached mp_adder_seq.
interface mp_adder_seq_if #(
   parameter int W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic         c_out;
   logic         ovf;

   modport master (
      output in_valid, a, b, sub, c_in, out_ready,
      input  in_ready, out_valid, y, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, sub, c_in, out_ready,
      output in_ready, out_valid, y, c_out, ovf
   );
endinterface

// File: rtl/mp_adder_seq.sv
// Multi-precision add/subtract: one N-bit chunk per cycle through a single
// Kogge-Stone prefix adder, with the chunk carry registered between cycles.

module pa #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] y,
   output logic         c_out
);
   localparam int L = $clog2(N);

   logic [N:0] c;

   // Level gl holds group generate/propagate over a span of 2^gl bits ending at each position.
   for (genvar gl = 0; gl <= L; gl++) begin : lvl
      logic [N-1:0] g;
      logic [N-1:0] p;
      if (gl == 0) begin : g_init
         assign g = a & b;
         assign p = a ^ b;
      end else begin : g_comb
         localparam int D = 1 << (gl - 1);
         for (genvar gi = 0; gi < N; gi++) begin : g_bit
            if (gi >= D) begin : g_merge
               assign g[gi] = lvl[gl-1].g[gi] | (lvl[gl-1].p[gi] & lvl[gl-1].g[gi-D]);
               assign p[gi] = lvl[gl-1].p[gi] & lvl[gl-1].p[gi-D];
            end else begin : g_pass
               assign g[gi] = lvl[gl-1].g[gi];
               assign p[gi] = lvl[gl-1].p[gi];
            end
         end
      end
   end

   assign c[0] = c_in;
   for (genvar gi = 0; gi < N; gi++) begin : g_carry
      assign c[gi+1] = lvl[L].g[gi] | (lvl[L].p[gi] & c_in);
   end

   assign y     = lvl[0].p ^ c[N-1:0];
   assign c_out = c[N];
endmodule

module mp_adder_seq #(
   parameter int N = 4,
   parameter int K = 4
) (
   input  logic          clk,
   input  logic          reset,
   mp_adder_seq_if.slave bus
);
   localparam int W  = N * K;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state_reg;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  y_reg;
   logic          carry_reg;
   logic          c_out_reg;
   logic          ovf_reg;
   logic [CW-1:0] cnt_reg;

   logic [N-1:0]  pa_a;
   logic [N-1:0]  pa_b;
   logic [N-1:0]  pa_y;
   logic          pa_c_out;
   logic          last_chunk;

   assign pa_a       = a_reg[int'(cnt_reg) * N +: N];
   assign pa_b       = b_reg[int'(cnt_reg) * N +: N];
   assign last_chunk = (cnt_reg == CW'(K - 1));

   pa #(
      .N (N)
   ) u_pa (
      .a     (pa_a),
      .b     (pa_b),
      .c_in  (carry_reg),
      .y     (pa_y),
      .c_out (pa_c_out)
   );

   // Handshake flags come straight from the state register, never from inputs.
   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.y         = y_reg;
   assign bus.c_out     = c_out_reg;
   assign bus.ovf       = ovf_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         y_reg     <= '0;
         carry_reg <= 1'b0;
         c_out_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg     <= bus.a;
                  // Subtraction is A + ~B + 1, so the +1 rides in as carry-in.
                  b_reg     <= bus.sub ? ~bus.b : bus.b;
                  carry_reg <= bus.sub | bus.c_in;
                  cnt_reg   <= '0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               y_reg[int'(cnt_reg) * N +: N] <= pa_y;
               carry_reg                      <= pa_c_out;
               if (last_chunk) begin
                  c_out_reg <= pa_c_out;
                  ovf_reg   <= (a_reg[W-1] == b_reg[W-1]) & (pa_y[N-1] != a_reg[W-1]);
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mp_adder_seq.sv
// Directed bench for mp_adder_seq (N=4, K=4): add, subtract, backpressure
// and asynchronous reset during RUN, each checked against hand-computed values.
module tb_mp_adder_seq;
   logic clk = 1'b0;
   logic reset;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   mp_adder_seq_if #(.W(16)) bus ();

   mp_adder_seq #(
      .N (4),
      .K (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Drives one operand set, waits (bounded) for out_valid, samples and consumes the result.
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         input logic cv, output logic [15:0] yv, output logic cov,
                         output logic ovv, output int lat);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = av;
      bus.b        = bv;
      bus.sub      = sv;
      bus.c_in     = cv;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.out_valid === 1'b1) break;
      end
      @(negedge clk);
      yv  = bus.y;
      cov = bus.c_out;
      ovv = bus.ovf;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      $display("op a=%h b=%h sub=%0d c_in=%0d -> y=%h c_out=%0d ovf=%0d lat=%0d",
               av, bv, sv, cv, yv, cov, ovv, lat);
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sub       = 1'b0;
      bus.c_in      = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.y !== 16'h0000) $display("FAIL reset_y: got %h expected 0000", bus.y);
      else pass_cnt++;
      total_cnt++;
      if (bus.c_out !== 1'b0 || bus.ovf !== 1'b0)
         $display("FAIL reset_flags: got c_out=%b ovf=%b expected 0 0", bus.c_out, bus.ovf);
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready);
      else pass_cnt++;
      $display("reset sequence done");
   endtask

   task automatic test_add();
      logic [15:0] av [4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF};
      logic [15:0] bv [4] = '{16'h0FCD, 16'h0001, 16'h0000, 16'h0001};
      logic        cv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [15:0] ey [4] = '{16'h2201, 16'h0000, 16'h0000, 16'h8000};
      logic        ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic        eo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [15:0] yv;
      logic        cov, ovv;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_op(av[i], bv[i], 1'b0, cv[i], yv, cov, ovv, lat);
         total_cnt++;
         if (yv !== ey[i]) $display("FAIL add_y[%0d]: got %h expected %h", i, yv, ey[i]);
         else pass_cnt++;
         total_cnt++;
         if (cov !== ec[i]) $display("FAIL add_c_out[%0d]: got %b expected %b", i, cov, ec[i]);
         else pass_cnt++;
         total_cnt++;
         if (ovv !== eo[i]) $display("FAIL add_ovf[%0d]: got %b expected %b", i, ovv, eo[i]);
         else pass_cnt++;
         total_cnt++;
         if (lat != 4) $display("FAIL add_latency[%0d]: got %0d expected 4", i, lat);
         else pass_cnt++;
      end
   endtask

   task automatic test_sub();
      logic [15:0] av [4] = '{16'h0005, 16'h8000, 16'h0005, 16'h0005};
      logic [15:0] bv [4] = '{16'h0007, 16'h0001, 16'h0007, 16'h0003};
      logic        cv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [15:0] ey [4] = '{16'hFFFE, 16'h7FFF, 16'hFFFE, 16'h0002};
      logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [15:0] yv;
      logic        cov, ovv;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_op(av[i], bv[i], 1'b1, cv[i], yv, cov, ovv, lat);
         total_cnt++;
         if (yv !== ey[i]) $display("FAIL sub_y[%0d]: got %h expected %h", i, yv, ey[i]);
         else pass_cnt++;
         total_cnt++;
         if (cov !== ec[i]) $display("FAIL sub_c_out[%0d]: got %b expected %b", i, cov, ec[i]);
         else pass_cnt++;
         total_cnt++;
         if (ovv !== eo[i]) $display("FAIL sub_ovf[%0d]: got %b expected %b", i, ovv, eo[i]);
         else pass_cnt++;
         total_cnt++;
         if (lat != 4) $display("FAIL sub_latency[%0d]: got %0d expected 4", i, lat);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 16'h1111;
      bus.b        = 16'h2222;
      bus.sub      = 1'b0;
      bus.c_in     = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.out_valid === 1'b1) break;
      end
      total_cnt++;
      if (lat != 4) $display("FAIL bp_latency: got %0d expected 4", lat);
      else pass_cnt++;
      // Three stalled DONE cycles while in_valid and a wiggle.
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = (i % 2 == 0);
         bus.a        = 16'hA5A0 + 16'(i);
         @(negedge clk);
         total_cnt++;
         if (bus.y !== 16'h3333) $display("FAIL bp_y_hold[%0d]: got %h expected 3333", i, bus.y);
         else pass_cnt++;
         total_cnt++;
         if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, bus.out_valid);
         else pass_cnt++;
         total_cnt++;
         if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
         else pass_cnt++;
         @(posedge clk);
         #1;
      end
      $display("backpressure held 3 cycles y=%h", bus.y);
      // Release with a new operand already presented: consumed now, accepted next cycle.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = 16'h0100;
      bus.b         = 16'h0023;
      bus.sub       = 1'b0;
      bus.c_in      = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b expected 0", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready);
      else pass_cnt++;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.out_valid === 1'b1) break;
      end
      @(negedge clk);
      total_cnt++;
      if (lat != 4) $display("FAIL bp_next_latency: got %0d expected 4", lat);
      else pass_cnt++;
      total_cnt++;
      if (bus.y !== 16'h0123) $display("FAIL bp_next_y: got %h expected 0123", bus.y);
      else pass_cnt++;
      $display("op after backpressure a=0100 b=0023 -> y=%h lat=%0d", bus.y, lat);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [15:0] yv;
      logic        cov, ovv;
      int          lat;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 16'hAAAA;
      bus.b        = 16'h1111;
      bus.sub      = 1'b0;
      bus.c_in     = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL rst_run_out_valid: got %b expected 0", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.y !== 16'h0000) $display("FAIL rst_run_y: got %h expected 0000", bus.y);
      else pass_cnt++;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL rst_run_in_ready: got %b expected 1", bus.in_ready);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL rst_hold_out_valid: got %b expected 0", bus.out_valid);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      $display("reset asserted during RUN at cnt=2");
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, yv, cov, ovv, lat);
      total_cnt++;
      if (yv !== 16'h0002) $display("FAIL rst_next_y: got %h expected 0002", yv);
      else pass_cnt++;
      total_cnt++;
      if (lat != 4) $display("FAIL rst_next_latency: got %0d expected 4", lat);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end
endmodule
